// File: rtl/mycpu_isa_pkg.sv
// ISA constants and field bundle shared by the instruction encoder and the CPU decoder.
package mycpu_isa_pkg;
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_LSL = 4'b1101;

  localparam logic [5:0] FUNCT_LDR  = 6'b011001;
  localparam logic [5:0] FUNCT_STR  = 6'b011000;
  localparam logic [1:0] FUNCT_B_HI = 2'b10;

  typedef enum logic [2:0] {
    CLS_DP_REG = 3'd0,
    CLS_DP_IMM = 3'd1,
    CLS_LDR    = 3'd2,
    CLS_STR    = 3'd3,
    CLS_B      = 3'd4
  } instr_class_e;

  // cls stays raw so out-of-range classes reach the legality check.
  typedef struct packed {
    logic [2:0]  cls;
    logic [3:0]  cmd;
    logic        s;
    logic [3:0]  cond;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [11:0] imm;
    logic [4:0]  shamt;
    logic [23:0] offset;
  } instr_fields_t;
endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packer with legality check; illegal words pack to zero.
module instr_pack
  import mycpu_isa_pkg::*;
(
  input  instr_fields_t f,
  output logic [31:0]   word,
  output logic          legal
);
  logic        cmd_ok, is_cmp, is_lsl, imm_i, s_bit;
  logic [3:0]  rd_f, rn_f;
  logic [11:0] src2;

  always_comb begin
    cmd_ok = f.cmd inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP, CMD_LSL};
    is_cmp = (f.cmd == CMD_CMP);
    is_lsl = (f.cmd == CMD_LSL);
    // LSL is always a register form, even if sent as DP-imm.
    imm_i  = (f.cls == CLS_DP_IMM) && !is_lsl;
    s_bit  = f.s | is_cmp;
    rd_f   = is_cmp ? 4'd0 : f.rd;
    rn_f   = is_lsl ? 4'd0 : f.rn;
    if (is_lsl)     src2 = {f.shamt, 2'b00, 1'b0, f.rm};
    else if (imm_i) src2 = f.imm;
    else            src2 = {8'b0, f.rm};

    word  = 32'h0;
    legal = 1'b1;
    case (f.cls)
      CLS_DP_REG, CLS_DP_IMM: begin
        word  = {f.cond, OP_DP, imm_i, f.cmd, s_bit, rn_f, rd_f, src2};
        legal = cmd_ok && !(imm_i && (f.imm > 12'd255));
      end
      CLS_LDR: word = {f.cond, OP_MEM, FUNCT_LDR, f.rn, f.rd, f.imm};
      CLS_STR: word = {f.cond, OP_MEM, FUNCT_STR, f.rn, f.rd, f.imm};
      CLS_B:   word = {f.cond, OP_B, FUNCT_B_HI, f.offset};
      default: legal = 1'b0;
    endcase
    if (!legal) word = 32'h0;
  end
endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs field-level instructions and streams them into imem from a base address.
module instr_encoder
  import mycpu_isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [3:0]        in_cmd,
  input  logic              in_s,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rm,
  input  logic [11:0]       in_imm,
  input  logic [4:0]        in_shamt,
  input  logic [23:0]       in_offset,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

  state_e            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  instr_fields_t     fields;
  logic [31:0]       word;
  logic              legal;
  logic              accept;

  always_comb begin
    fields = '{cls: in_class, cmd: in_cmd, s: in_s, cond: in_cond, rd: in_rd,
               rn: in_rn, rm: in_rm, imm: in_imm, shamt: in_shamt, offset: in_offset};
  end

  instr_pack u_pack (.f(fields), .word(word), .legal(legal));

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      remaining  <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done    <= 1'b0;
      imem_we <= accept;
      if (accept) begin
        imem_addr  <= addr;
        imem_wdata <= word;
        addr       <= addr + 1'b1;
        if (!legal) error <= 1'b1;
      end
      case (state)
        S_IDLE: if (start) begin
          addr      <= base_addr;
          remaining <= count;
          error     <= 1'b0;
          busy      <= 1'b1;
          // An empty job passes through DRAIN so done lands 2 cycles after start.
          if (count == '0) state <= S_DRAIN;
          else begin
            state    <= S_LOAD;
            in_ready <= 1'b1;
          end
        end
        S_LOAD: if (accept) begin
          remaining <= remaining - 1'b1;
          if (remaining == (ADDR_W+1)'(1)) begin
            in_ready <= 1'b0;
            state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: scoreboard of expected imem writes checked on the falling edge.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_s;
  logic [7:0]  base_addr;
  logic [8:0]  count;
  logic [2:0]  in_class;
  logic [3:0]  in_cmd, in_cond, in_rd, in_rn, in_rm;
  logic [11:0] in_imm;
  logic [4:0]  in_shamt;
  logic [23:0] in_offset;
  logic        in_ready, imem_we, busy, done, error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] c;
  } sb_t;

  sb_t         sb[$];
  int          passed = 0, total = 0, wr_cnt = 0;
  logic [31:0] cyc = 0;
  logic [7:0]  exp_addr;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class), .in_cmd(in_cmd),
    .in_s(in_s), .in_cond(in_cond), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_imm(in_imm), .in_shamt(in_shamt), .in_offset(in_offset),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scoreboard consumer: each write must match the next expected word, address and cycle.
  always @(negedge clk) begin
    sb_t e;
    if (imem_we) begin
      wr_cnt++;
      chk("write_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.a));
        chk("wr_data", imem_wdata, e.d);
        chk("wr_cycle", cyc, e.c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] n);
    start = 1'b1; base_addr = b; count = n;
    tick();
    start = 1'b0;
    exp_addr = b;
  endtask

  task automatic send(input logic [2:0] cls, input logic [3:0] cmd, input logic s,
                      input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                      input logic [11:0] imm, input logic [4:0] shamt,
                      input logic [23:0] off, input logic [31:0] exp, output int waits);
    in_class = cls; in_cmd = cmd; in_s = s; in_cond = 4'hE; in_rd = rd; in_rn = rn;
    in_rm = rm; in_imm = imm; in_shamt = shamt; in_offset = off; in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 20) begin
      tick();
      waits++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    else begin
      sb.push_back('{a: exp_addr, d: exp, c: cyc + 1});
      exp_addr++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  // Called in the cycle after the last accept (or after start for an empty job).
  task automatic check_done_seq(input string tag);
    chk({tag, "_ready_low"}, 32'(in_ready), 32'd0);
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int w, snap;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; base_addr = '0; count = '0;
    in_class = '0; in_cmd = '0; in_s = 1'b0; in_cond = 4'hE; in_rd = '0; in_rn = '0;
    in_rm = '0; in_imm = '0; in_shamt = '0; in_offset = '0; exp_addr = '0;
    tick(); tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Encoding vectors.
    do_start(8'h10, 9'd7);
    chk("load_ready", 32'(in_ready), 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
    send(3'd1, 4'b0100, 1'b0, 4'd1, 4'd2, 4'd0, 12'd5,   5'd0, 24'd0, 32'hE2821005, w);
    send(3'd0, 4'b0010, 1'b1, 4'd3, 4'd4, 4'd5, 12'd0,   5'd0, 24'd0, 32'hE0543005, w);
    send(3'd1, 4'b1010, 1'b0, 4'd7, 4'd1, 4'd0, 12'd0,   5'd0, 24'd0, 32'hE3510000, w);
    send(3'd0, 4'b1101, 1'b0, 4'd0, 4'd5, 4'd1, 12'd0,   5'd2, 24'd0, 32'hE1A00101, w);
    send(3'd2, 4'b0000, 1'b0, 4'd2, 4'd0, 4'd0, 12'd8,   5'd0, 24'd0, 32'hE5902008, w);
    send(3'd3, 4'b0000, 1'b0, 4'd2, 4'd0, 4'd0, 12'd8,   5'd0, 24'd0, 32'hE5802008, w);
    send(3'd4, 4'b0000, 1'b0, 4'd0, 4'd0, 4'd0, 12'd0,   5'd0, 24'hFFFFFE, 32'hEAFFFFFE, w);
    check_done_seq("enc");
    chk("enc_no_error", 32'(error), 32'd0);
    tick();

    // Address wrap with continuous valid: no wait cycles allowed.
    do_start(8'hFE, 9'd3);
    send(3'd1, 4'b1100, 1'b0, 4'd6, 4'd7, 4'd0, 12'hFF, 5'd0, 24'd0, 32'hE38760FF, w);
    chk("wrap_wait0", 32'(w), 32'd0);
    send(3'd0, 4'b0010, 1'b1, 4'd3, 4'd4, 4'd5, 12'd0,  5'd0, 24'd0, 32'hE0543005, w);
    chk("wrap_wait1", 32'(w), 32'd0);
    send(3'd4, 4'b0000, 1'b0, 4'd0, 4'd0, 4'd0, 12'd0,  5'd0, 24'hFFFFFE, 32'hEAFFFFFE, w);
    chk("wrap_wait2", 32'(w), 32'd0);
    check_done_seq("wrap");
    tick();

    // Illegal words, plus a start pulse while busy that must be ignored.
    do_start(8'h80, 9'd5);
    start = 1'b1; base_addr = 8'h40; count = 9'd0;
    tick();
    start = 1'b0;
    send(3'd1, 4'b0100, 1'b0, 4'd1, 4'd2, 4'd0, 12'd5,   5'd0, 24'd0, 32'hE2821005, w);
    chk("err_clear_before", 32'(error), 32'd0);
    send(3'd6, 4'b0100, 1'b0, 4'd1, 4'd2, 4'd0, 12'd5,   5'd0, 24'd0, 32'h0, w);
    chk("err_set", 32'(error), 32'd1);
    send(3'd1, 4'b0100, 1'b0, 4'd1, 4'd2, 4'd0, 12'd256, 5'd0, 24'd0, 32'h0, w);
    send(3'd0, 4'b0001, 1'b0, 4'd1, 4'd2, 4'd3, 12'd0,   5'd0, 24'd0, 32'h0, w);
    send(3'd3, 4'b0000, 1'b0, 4'd2, 4'd0, 4'd0, 12'd8,   5'd0, 24'd0, 32'hE5802008, w);
    check_done_seq("err");
    chk("err_sticky", 32'(error), 32'd1);
    tick();

    // Empty job: done without writes; accepted start clears error.
    snap = wr_cnt;
    do_start(8'h33, 9'd0);
    chk("zero_err_cleared", 32'(error), 32'd0);
    check_done_seq("zero");
    chk("zero_no_writes", 32'(wr_cnt), 32'(snap));
    tick();

    // Reset mid-job.
    do_start(8'h20, 9'd4);
    send(3'd1, 4'b0100, 1'b0, 4'd1, 4'd2, 4'd0, 12'd5, 5'd0, 24'd0, 32'hE2821005, w);
    in_class = 3'd2; in_valid = 1'b1; rst_n = 1'b0;
    tick();
    snap = wr_cnt;
    check_reset_vals("midrst");
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    tick();
    chk("midrst_no_writes", 32'(wr_cnt), 32'(snap));
    chk("midrst_idle", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
